// File: rtl/alu_datapath.sv
// Execute-stage datapath slice: operand-B select, 16-code ALU, write-back address/data
// selection, plus a capture-enabled registered copy of the ALU result and flags.
module alu_datapath (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] alu_a,
    input  logic [31:0] reg2_data,
    input  logic [18:0] imm19,
    input  logic [3:0]  alu_control,
    input  logic        C_reg2_aluB_mux,
    input  logic        C_ART_data,
    input  logic        C_ART_reg,
    input  logic [3:0]  rd_ar,
    input  logic [3:0]  rd_ti,
    input  logic        capture,
    output logic [31:0] alu_b,
    output logic [31:0] alu_result,
    output logic        alu_cout,
    output logic        alu_zero,
    output logic [3:0]  write_reg,
    output logic [31:0] write_data,
    output logic [31:0] result_q,
    output logic        cout_q,
    output logic        zero_q
);

    localparam int unsigned DataW  = 32;
    localparam int unsigned ImmW   = 19;
    localparam int unsigned ShamtW = 5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_SRA   = 4'h8,
        OP_SLT   = 4'h9,
        OP_SLTU  = 4'hA,
        OP_PASSB = 4'hB,
        OP_NOTA  = 4'hC,
        OP_NEG   = 4'hD
    } alu_op_e;

    logic [DataW-1:0]  imm_ext;
    logic [DataW:0]    sum;
    logic [ShamtW-1:0] shamt;

    assign imm_ext = {{(DataW-ImmW){imm19[ImmW-1]}}, imm19};
    assign shamt   = alu_b[ShamtW-1:0];

    // Selects use an if on == 1'b1 so an unknown select falls through to input 0.
    always_comb begin
        alu_b      = reg2_data;
        write_data = alu_result;
        write_reg  = rd_ar;
        if (C_reg2_aluB_mux == 1'b1) alu_b      = imm_ext;
        if (C_ART_data == 1'b1)      write_data = imm_ext;
        if (C_ART_reg == 1'b1)       write_reg  = rd_ti;
    end

    // ALU: carry is only meaningful for the adder-based codes (ADD, SUB, NEG).
    always_comb begin
        sum        = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_op_e'(alu_control))
            OP_ADD: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[DataW-1:0];
                alu_cout   = sum[DataW];
            end
            OP_SUB: begin
                sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + (DataW+1)'(1);
                alu_result = sum[DataW-1:0];
                alu_cout   = sum[DataW];
            end
            OP_AND:   alu_result = alu_a & alu_b;
            OP_OR:    alu_result = alu_a | alu_b;
            OP_XOR:   alu_result = alu_a ^ alu_b;
            OP_NOR:   alu_result = ~(alu_a | alu_b);
            OP_SLL:   alu_result = alu_a << shamt;
            OP_SRL:   alu_result = alu_a >> shamt;
            OP_SRA:   alu_result = DataW'($signed(alu_a) >>> shamt);
            OP_SLT:   alu_result = DataW'($signed(alu_a) < $signed(alu_b));
            OP_SLTU:  alu_result = DataW'(alu_a < alu_b);
            OP_PASSB: alu_result = alu_b;
            OP_NOTA:  alu_result = ~alu_a;
            OP_NEG: begin
                sum        = {1'b0, ~alu_a} + (DataW+1)'(1);
                alu_result = sum[DataW-1:0];
                alu_cout   = sum[DataW];
            end
            default: begin
                alu_result = '0;
                alu_cout   = 1'b0;
            end
        endcase
    end

    assign alu_zero = ~|alu_result;

    // One-cycle-late debug/forwarding copy of the result and flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (capture) begin
            result_q <= alu_result;
            cout_q   <= alu_cout;
            zero_q   <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed test-plan cases, then random
// vectors against an arithmetic reference model, including the registered stage.
module tb_alu_datapath;

    logic        CLK;
    logic        RESET;
    logic [31:0] alu_a;
    logic [31:0] reg2_data;
    logic [18:0] imm19;
    logic [3:0]  alu_control;
    logic        C_reg2_aluB_mux;
    logic        C_ART_data;
    logic        C_ART_reg;
    logic [3:0]  rd_ar;
    logic [3:0]  rd_ti;
    logic        capture;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_zero;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] result_q;
    logic        cout_q;
    logic        zero_q;

    int checks;
    int failures;

    alu_datapath dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .alu_a           (alu_a),
        .reg2_data       (reg2_data),
        .imm19           (imm19),
        .alu_control     (alu_control),
        .C_reg2_aluB_mux (C_reg2_aluB_mux),
        .C_ART_data      (C_ART_data),
        .C_ART_reg       (C_ART_reg),
        .rd_ar           (rd_ar),
        .rd_ti           (rd_ti),
        .capture         (capture),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .alu_cout        (alu_cout),
        .alu_zero        (alu_zero),
        .write_reg       (write_reg),
        .write_data      (write_data),
        .result_q        (result_q),
        .cout_q          (cout_q),
        .zero_q          (zero_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the operation table with plain arithmetic.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op,
                                    output logic [31:0] r, output logic c);
        logic [63:0] wide;
        int sh;
        sh = int'(b[4:0]);
        r = 32'd0;
        c = 1'b0;
        case (op)
            4'h0: begin wide = {32'd0, a} + {32'd0, b}; r = wide[31:0]; c = wide[32]; end
            4'h1: begin r = a - b; c = (a >= b); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~(a | b);
            4'h6: r = a << sh;
            4'h7: r = a >> sh;
            4'h8: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'h9: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'hA: r = (a < b) ? 32'd1 : 32'd0;
            4'hB: r = b;
            4'hC: r = ~a;
            4'hD: begin r = 32'd0 - a; c = (a == 32'd0); end
            default: begin r = 32'd0; c = 1'b0; end
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] r2, input logic [18:0] imm,
                         input logic [3:0] op, input logic selb, input logic seld,
                         input logic selr);
        alu_a           = a;
        reg2_data       = r2;
        imm19           = imm;
        alu_control     = op;
        C_reg2_aluB_mux = selb;
        C_ART_data      = seld;
        C_ART_reg       = selr;
        #1;
    endtask

    logic [31:0] exp_b, exp_r, exp_wd, mdl_res_q;
    logic        exp_c, mdl_cout_q, mdl_zero_q;
    logic [3:0]  exp_wr;

    initial begin
        checks = 0;
        failures = 0;
        RESET = 1'b1;
        capture = 1'b0;
        rd_ar = 4'd0;
        rd_ti = 4'd0;
        drive(32'd0, 32'd0, 19'd0, 4'h0, 1'b0, 1'b0, 1'b0);

        RESET = 1'b0;
        #1;
        chk("reset_result_q", result_q, 32'd0);
        chk("reset_cout_q", 32'(cout_q), 32'd0);
        chk("reset_zero_q", 32'(zero_q), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // AR add
        rd_ar = 4'd3;
        drive(32'd5, 32'd7, 19'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ar_add_result", alu_result, 32'd12);
        chk("ar_add_wreg", 32'(write_reg), 32'd3);
        chk("ar_add_wdata", write_data, 32'd12);
        chk("ar_add_cout", 32'(alu_cout), 32'd0);

        // Immediate sign extension
        drive(32'd1, 32'd0, 19'h7FFFF, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("imm_b", alu_b, 32'hFFFF_FFFF);
        chk("imm_result", alu_result, 32'd0);
        chk("imm_cout", 32'(alu_cout), 32'd1);
        chk("imm_zero", 32'(alu_zero), 32'd1);
        drive(32'd1, 32'd0, 19'h7FFFF, 4'h0, 1'b1, 1'b1, 1'b0);
        chk("imm_wdata", write_data, 32'hFFFF_FFFF);

        // SUB / compare
        drive(32'd3, 32'd5, 19'd0, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("sub_result", alu_result, 32'hFFFF_FFFE);
        chk("sub_cout", 32'(alu_cout), 32'd0);
        drive(32'd3, 32'd5, 19'd0, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("slt_3_5", alu_result, 32'd1);
        drive(32'd3, 32'd5, 19'd0, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("sltu_3_5", alu_result, 32'd1);
        drive(32'hFFFF_FFFF, 32'd1, 19'd0, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("slt_m1_1", alu_result, 32'd1);
        drive(32'hFFFF_FFFF, 32'd1, 19'd0, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("sltu_m1_1", alu_result, 32'd0);

        // Shifts, including shamt taken from B[4:0] only
        drive(32'h8000_0000, 32'd4, 19'd0, 4'h6, 1'b0, 1'b0, 1'b0);
        chk("sll", alu_result, 32'd0);
        drive(32'h8000_0000, 32'd4, 19'd0, 4'h7, 1'b0, 1'b0, 1'b0);
        chk("srl", alu_result, 32'h0800_0000);
        drive(32'h8000_0000, 32'd4, 19'd0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("sra", alu_result, 32'hF800_0000);
        drive(32'h8000_0000, 32'h24, 19'd0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("sra_shamt_mask", alu_result, 32'hF800_0000);

        // NEG carry and unused codes
        drive(32'd0, 32'd0, 19'd0, 4'hD, 1'b0, 1'b0, 1'b0);
        chk("neg0_cout", 32'(alu_cout), 32'd1);
        drive(32'd9, 32'd9, 19'd0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("op_f_result", alu_result, 32'd0);

        // Write-register select
        rd_ti = 4'd9;
        rd_ar = 4'd2;
        drive(32'd0, 32'd0, 19'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("wreg_ti", 32'(write_reg), 32'd9);
        drive(32'd0, 32'd0, 19'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("wreg_ar", 32'(write_reg), 32'd2);

        // Register stage: async reset mid-cycle, capture ignored in reset, then load/hold
        @(negedge CLK);
        drive(32'h1234, 32'd0, 19'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        capture = 1'b1;
        @(posedge CLK);
        #1;
        chk("load_1234", result_q, 32'h1234);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_reset_result_q", result_q, 32'd0);
        @(posedge CLK);
        #1;
        chk("capture_in_reset", result_q, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        drive(32'd1, 32'd1, 19'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        chk("capture_add", result_q, 32'd2);
        @(negedge CLK);
        capture = 1'b0;
        drive(32'd77, 32'd1, 19'd0, 4'h1, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        chk("hold_result_q", result_q, 32'd2);
        chk("hold_zero_q", 32'(zero_q), 32'd0);

        // Random vectors against the reference model
        mdl_res_q  = 32'd2;
        mdl_cout_q = 1'b0;
        mdl_zero_q = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            logic [18:0] ri;
            logic [3:0]  rop;
            logic        sb, sd, sr, cap;
            @(negedge CLK);
            ra  = $urandom();
            rb  = $urandom();
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = ra;
            ri  = 19'($urandom());
            rop = 4'($urandom_range(0, 15));
            sb  = 1'($urandom());
            sd  = 1'($urandom());
            sr  = 1'($urandom());
            cap = 1'($urandom());
            rd_ar = 4'($urandom());
            rd_ti = 4'($urandom());
            capture = cap;
            drive(ra, rb, ri, rop, sb, sd, sr);

            exp_b  = sb ? {{13{ri[18]}}, ri} : rb;
            ref_alu(ra, exp_b, rop, exp_r, exp_c);
            exp_wd = sd ? {{13{ri[18]}}, ri} : exp_r;
            exp_wr = sr ? rd_ti : rd_ar;
            chk("rnd_alu_b", alu_b, exp_b);
            chk("rnd_result", alu_result, exp_r);
            chk("rnd_cout", 32'(alu_cout), 32'(exp_c));
            chk("rnd_zero", 32'(alu_zero), 32'(exp_r == 32'd0));
            chk("rnd_wdata", write_data, exp_wd);
            chk("rnd_wreg", 32'(write_reg), 32'(exp_wr));

            @(posedge CLK);
            #1;
            if (cap) begin
                mdl_res_q  = exp_r;
                mdl_cout_q = exp_c;
                mdl_zero_q = (exp_r == 32'd0);
            end
            chk("rnd_result_q", result_q, mdl_res_q);
            chk("rnd_cout_q", 32'(cout_q), 32'(mdl_cout_q));
            chk("rnd_zero_q", 32'(zero_q), 32'(mdl_zero_q));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
